// File: rtl/sgf_div_pkg.sv
// sgf_div_pkg
// Shared definitions for the sequential significand divider:
//   - state_t      : FSM state encoding (IDLE, ITER, DONE)
//   - quot_width() : quotient width for a given significand width (SW+2)
//   - DIV_ZERO_Q   : saturated quotient pattern used for divide-by-zero
// Configuration macro used by the divider: SGF_DIV_EARLY_EXIT_EN.
package sgf_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // The quotient carries two integer positions above the SW-bit
    // fraction so that both A >= B and A < B results fit.
    function automatic int quot_width(input int sw);
        return sw + 2;
    endfunction

    // Wide enough for any practical SW; the divider slices what it needs.
    localparam logic [127:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/sgf_div_step.sv
// sgf_div_step
// One combinational restoring-division step.
// Ports:
//   rem_i  [SW:0]   current partial remainder
//   div_i  [SW-1:0] divisor
//   qbit_o          quotient bit produced by this step
//   rem_o  [SW:0]   next partial remainder, already shifted left by one
module sgf_div_step
    import sgf_div_pkg::*;
#(
    parameter int SW = 24
) (
    input  logic [SW:0]   rem_i,
    input  logic [SW-1:0] div_i,
    output logic          qbit_o,
    output logic [SW:0]   rem_o
);

    logic [SW:0] div_ext;
    logic [SW:0] diff;
    logic [SW:0] rem_sel;
    logic        ge;

    always_comb begin
        div_ext = {1'b0, div_i};
        ge      = (rem_i >= div_ext);
        diff    = rem_i - div_ext;
        rem_sel = ge ? diff : rem_i;
        qbit_o  = ge;
        // rem_sel < divisor < 2^SW, so its top bit is zero and the shift
        // drops nothing when the A < 2B precondition holds.
        rem_o   = {rem_sel[SW-1:0], 1'b0};
    end

endmodule

// File: rtl/sgf_divider_seq.sv
// sgf_divider_seq
// Sequential radix-2 restoring divider for normalized significands.
// Computes quotient_o = floor(A * 2^(SW+1) / B) with one quotient bit per
// clock, plus a sticky bit (final remainder != 0) for rounding.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start_i       request, accepted only while ready_o is high
//   Data_A_i      dividend significand (SW bits), sampled on acceptance
//   Data_B_i      divisor significand (SW bits), sampled on acceptance
//   ready_o       high only in IDLE
//   done_o        one-cycle pulse when the result is valid
//   quotient_o    SW+2 quotient bits, held until the next acceptance
//   sticky_o      remainder non-zero, held with quotient_o
//   div_zero_o    divisor was zero, held with quotient_o
// Optional feature macro: SGF_DIV_EARLY_EXIT_EN -- finish as soon as the
// partial remainder becomes zero (results identical, latency variable).
module sgf_divider_seq
    import sgf_div_pkg::*;
#(
    parameter int SW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SW-1:0]     Data_A_i,
    input  logic [SW-1:0]     Data_B_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [SW+1:0]     quotient_o,
    output logic              sticky_o,
    output logic              div_zero_o
);

    localparam int QW = quot_width(SW);
    localparam int CW = $clog2(SW + 2);

    state_t          state_q;
    logic [SW:0]     rem_q;
    logic [SW-1:0]   div_q;
    logic [QW-1:0]   quot_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;
    logic            done_q;
    logic            sticky_q;
    logic            div_zero_q;

    logic            qbit_d;
    logic [SW:0]     rem_d;
    logic [QW-1:0]   quot_d;

    sgf_div_step #(.SW(SW)) u_step (
        .rem_i  (rem_q),
        .div_i  (div_q),
        .qbit_o (qbit_d),
        .rem_o  (rem_d)
    );

    assign quot_d = {quot_q[QW-2:0], qbit_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            div_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            sticky_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ready_q <= 1'b0;
                        if (Data_B_i == '0) begin
                            state_q    <= DONE;
                            quot_q     <= DIV_ZERO_Q[QW-1:0];
                            sticky_q   <= 1'b1;
                            div_zero_q <= 1'b1;
                        end else begin
                            state_q    <= ITER;
                            rem_q      <= {1'b0, Data_A_i};
                            div_q      <= Data_B_i;
                            quot_q     <= '0;
                            cnt_q      <= CW'(SW + 1);
                            div_zero_q <= 1'b0;
                        end
                    end
                end

                ITER: begin
                    quot_q <= quot_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q - 1'b1;
`ifdef SGF_DIV_EARLY_EXIT_EN
                    // A zero remainder means every remaining quotient bit
                    // is zero: align the bits produced so far and finish.
                    if (rem_d == '0) begin
                        quot_q   <= quot_d << cnt_q;
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        sticky_q <= 1'b0;
                    end else
`endif
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        sticky_q <= (rem_d != '0);
                    end
                end

                DONE: begin
                    // Arriving from ITER the pulse is already up. The
                    // divide-by-zero path enters with done low, so it
                    // raises the pulse here and leaves one cycle later.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign quotient_o = quot_q;
    assign sticky_o   = sticky_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_sgf_divider_seq.sv
// tb_sgf_divider_seq
// Directed bench for sgf_divider_seq with SW=24. Expected quotients are
// floor(A * 2^25 / B) worked out by hand for each vector.
module tb_sgf_divider_seq;

    localparam int SW = 24;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [SW-1:0]     Data_A_i;
    logic [SW-1:0]     Data_B_i;
    logic              ready_o;
    logic              done_o;
    logic [SW+1:0]     quotient_o;
    logic              sticky_o;
    logic              div_zero_o;

    int checks = 0;
    int errors = 0;

    sgf_divider_seq #(.SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .Data_A_i   (Data_A_i),
        .Data_B_i   (Data_B_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .quotient_o (quotient_o),
        .sticky_o   (sticky_o),
        .div_zero_o (div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one divide; latency is the number of edges after the acceptance
    // edge E0 such that done_o is high in the cycle after edge E0+lat.
    task automatic do_op(input string name, input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic [SW+1:0] exp_q, input logic exp_s, input logic exp_z,
                         input int exp_lat);
        int lat;
        chk({name, ".ready_before"}, 64'(ready_o), 64'd1);
        Data_A_i = a;
        Data_B_i = b;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        lat = 0;
        while (!done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, ".done"}, 64'(done_o), 64'd1);
`ifdef SGF_DIV_EARLY_EXIT_EN
        chk({name, ".lat_bound"}, 64'(lat >= 1 && lat <= exp_lat), 64'd1);
`else
        chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
`endif
        chk({name, ".quotient"}, 64'(quotient_o), 64'(exp_q));
        chk({name, ".sticky"}, 64'(sticky_o), 64'(exp_s));
        chk({name, ".div_zero"}, 64'(div_zero_o), 64'(exp_z));
        $display("op %s A=0x%06h B=0x%06h Q=0x%07h sticky=%0b dz=%0b lat=%0d",
                 name, a, b, quotient_o, sticky_o, div_zero_o, lat);
        @(negedge clk);
        chk({name, ".pulse_end"}, 64'(done_o), 64'd0);
        chk({name, ".ready_after"}, 64'(ready_o), 64'd1);
        chk({name, ".q_held"}, 64'(quotient_o), 64'(exp_q));
    endtask

    initial begin
        int done_seen;
        rst      = 1'b1;
        start_i  = 1'b0;
        Data_A_i = '0;
        Data_B_i = '0;
        repeat (2) @(negedge clk);

        chk("reset.ready", 64'(ready_o), 64'd1);
        chk("reset.done", 64'(done_o), 64'd0);
        chk("reset.quotient", 64'(quotient_o), 64'd0);
        chk("reset.sticky", 64'(sticky_o), 64'd0);
        chk("reset.div_zero", 64'(div_zero_o), 64'd0);
        $display("reset released");
        rst = 1'b0;
        @(negedge clk);

        // 1.0 / 1.0 -> 2^25
        do_op("one_one", 24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 26);
        // 1.5 / 1.0
        do_op("c0_80", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 26);
        // (2^24-1)/2^23 * 2^25 = 2^26 - 4, exact
        do_op("ff_80", 24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 26);
        // 2^48/(3*2^22) = 2^26/3, inexact, Q[25]=0
        do_op("80_c0", 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 26);
        chk("80_c0.q_msb", 64'(quotient_o[SW+1]), 64'd0);
        // 2^48/(2^24-1) = 2^24 + 1 remainder 1
        do_op("80_ff", 24'h800000, 24'hFFFFFF, 26'h1000001, 1'b1, 1'b0, 26);
        // equal maximal operands
        do_op("ff_ff", 24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 1'b0, 26);

        // divide by zero, then a valid divide clears div_zero_o
        do_op("div0", 24'h9ABCDE, 24'h000000, 26'h3FFFFFF, 1'b1, 1'b1, 1);
        do_op("after_div0", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 26);

        // start_i pulsed mid-iteration with other operands must be ignored
        Data_A_i = 24'hC00000;
        Data_B_i = 24'h800000;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        repeat (5) @(negedge clk);
        Data_A_i = 24'h800000;
        Data_B_i = 24'hC00000;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 60 && done_seen == 0; i++) begin
            if (done_o) done_seen = 1;
            else @(negedge clk);
        end
        chk("ignore_start.done", 64'(done_seen), 64'd1);
        chk("ignore_start.quotient", 64'(quotient_o), 64'h3000000);
        chk("ignore_start.sticky", 64'(sticky_o), 64'd0);
        $display("op ignore_start Q=0x%07h sticky=%0b", quotient_o, sticky_o);
        repeat (2) @(negedge clk);

        // reset in the middle of an iteration aborts with no done pulse
        Data_A_i = 24'h800000;
        Data_B_i = 24'hC00000;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset.ready", 64'(ready_o), 64'd1);
        chk("mid_reset.quotient", 64'(quotient_o), 64'd0);
        chk("mid_reset.done", 64'(done_o), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) done_seen = 1;
            @(negedge clk);
        end
        chk("mid_reset.no_done", 64'(done_seen), 64'd0);
        $display("op mid_reset ready=%0b Q=0x%07h", ready_o, quotient_o);

        // normal operation resumes after the abort
        do_op("post_reset", 24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
